// File: rtl/misr_8_bist.sv
// misr_8_bist: 8-bit Galois MISR with IDLE/RUN/DONE BIST sequencing and golden compare.
// Compacts din for NUM_PATTERNS cycles after start, then holds signature and pass.
module misr_8_bist #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] POLY         = 8'h1D,
    parameter logic [WIDTH-1:0] SEED         = 8'h00,
    parameter int               NUM_PATTERNS = 255,
    parameter int               CNT_W        = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] golden,
    output logic             lfsr_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] pattern_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_PATTERNS - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d, next_sig;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pass_q, pass_d;

    // din only reaches state through the RUN branch, so X outside RUN is harmless
    assign next_sig = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ din;

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        if (state_q == RUN) begin
            sig_d = next_sig;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                state_d = DONE;
                pass_d  = next_sig == golden;
            end
        end else if (start) begin
            state_d = RUN;
            sig_d   = SEED;
            cnt_d   = '0;
            pass_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    assign busy        = state_q == RUN;
    assign lfsr_en     = busy;
    assign done        = state_q == DONE;
    assign pass        = pass_q;
    assign signature   = sig_q;
    assign pattern_cnt = cnt_q;
endmodule

// File: tb/tb_misr_8_bist.sv
// tb_misr_8_bist: randomized and directed checks of misr_8_bist at N=3, N=1 and N=255
// against a polynomial-arithmetic signature model.
module tb_misr_8_bist;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start3 = 1'b0, start1 = 1'b0, start_b = 1'b0;
    logic [7:0] din = 8'h00, golden = 8'h00;
    logic       en3, busy3, done3, pass3, en1, busy1, done1, pass1, en_b, busy_b, done_b, pass_b;
    logic [7:0] sig3, cnt3, sig1, cnt1, sig_b, cnt_b;
    int         n_asrt = 0, n_fail = 0;

    always #5 clk = ~clk;

    misr_8_bist #(.NUM_PATTERNS(3)) u3 (
        .CLK(clk), .RST(rst), .start(start3), .din(din), .golden(golden),
        .lfsr_en(en3), .busy(busy3), .done(done3), .pass(pass3),
        .signature(sig3), .pattern_cnt(cnt3)
    );
    misr_8_bist #(.NUM_PATTERNS(1)) u1 (
        .CLK(clk), .RST(rst), .start(start1), .din(din), .golden(golden),
        .lfsr_en(en1), .busy(busy1), .done(done1), .pass(pass1),
        .signature(sig1), .pattern_cnt(cnt1)
    );
    misr_8_bist u_b (
        .CLK(clk), .RST(rst), .start(start_b), .din(din), .golden(golden),
        .lfsr_en(en_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .signature(sig_b), .pattern_cnt(cnt_b)
    );

    // signature * x mod (x^8+x^4+x^3+x^2+1), plus the new response word
    function automatic logic [7:0] ref_step(input logic [7:0] s, input logic [7:0] d);
        int t;
        t = int'(s) * 2;
        if (t > 255) t = t ^ 'h11D;
        return 8'(t) ^ d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run3(input logic [23:0] d, input logic [7:0] g, input bit poke);
        logic [7:0] exp;
        exp = 8'h00;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        chk("start_sig", sig3, 8'h00);
        chk("start_cnt", cnt3, 0);
        chk("start_pass", pass3, 0);
        chk("start_busy", busy3, 1);
        chk("start_en", en3, 1);
        for (int i = 0; i < 3; i++) begin
            din = d[8*i +: 8];
            golden = g;
            if (poke && i == 1) start3 = 1'b1;
            tick();
            start3 = 1'b0;
            exp = ref_step(exp, d[8*i +: 8]);
            chk("run_sig", sig3, exp);
            chk("run_cnt", cnt3, i + 1);
            chk("run_busy", busy3, i < 2);
            chk("run_done", done3, i == 2);
        end
        chk("pass", pass3, exp == g);
        din = 8'bx;
        golden = 8'bx;
        tick();
        chk("hold_sig", sig3, exp);
        chk("hold_cnt", cnt3, 3);
        chk("hold_pass", pass3, exp == g);
        chk("hold_done", done3, 1);
        chk("hold_en", en3, 0);
    endtask

    task automatic run_b(input bit zero);
        logic [7:0] exp;
        int         en_cnt;
        exp = 8'h00;
        en_cnt = 0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 255; i++) begin
            en_cnt += int'(en_b);
            din = zero ? 8'h00 : 8'($urandom);
            exp = ref_step(exp, din);
            golden = zero ? 8'h00 : exp;
            tick();
        end
        chk("b_en_cycles", en_cnt, 255);
        chk("b_sig", sig_b, exp);
        chk("b_cnt", cnt_b, 255);
        chk("b_done", done_b, 1);
        chk("b_pass", pass_b, 1);
        din = 8'bx;
    endtask

    initial begin
        logic [23:0] d;
        logic [7:0]  e;
        #2;
        chk("rst_sig", sig3, 8'h00);
        chk("rst_cnt", cnt3, 0);
        chk("rst_busy", busy3, 0);
        chk("rst_done", done3, 0);
        chk("rst_pass", pass3, 0);
        chk("rst_en", en3, 0);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("idle_busy", busy3, 0);

        run3({8'h00, 8'h00, 8'h01}, 8'h04, 0);
        chk("lsb_sig", sig3, 8'h04);
        run3({8'h00, 8'h00, 8'h01}, 8'h05, 1);
        chk("lsb_fail_pass", pass3, 0);
        run3({8'h00, 8'h00, 8'h80}, 8'h3A, 0);
        chk("fb_sig", sig3, 8'h3A);
        run3({8'h00, 8'h00, 8'h80}, 8'h3A, 0);
        chk("fb_rerun_sig", sig3, 8'h3A);

        for (int r = 0; r < 6; r++) begin
            d = 24'($urandom);
            e = ref_step(ref_step(ref_step(8'h00, d[7:0]), d[15:8]), d[23:16]);
            run3(d, r[0] ? e : e ^ 8'(1 << (r % 8)), r == 3);
        end

        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        din = 8'h5A;
        tick();
        din = 8'hC3;
        tick();
        chk("mid_cnt", cnt3, 2);
        #2 rst = 1'b1;
        #1;
        chk("async_sig", sig3, 8'h00);
        chk("async_cnt", cnt3, 0);
        chk("async_busy", busy3, 0);
        chk("async_en", en3, 0);
        chk("async_done", done3, 0);
        chk("async_pass", pass3, 0);
        tick();
        #2 rst = 1'b0;
        repeat (3) tick();
        chk("post_rst_busy", busy3, 0);
        chk("post_rst_done", done3, 0);
        chk("post_rst_cnt", cnt3, 0);

        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("n1_busy", busy1, 1);
        din = 8'($urandom);
        golden = ref_step(8'h00, din);
        tick();
        chk("n1_sig", sig1, golden);
        chk("n1_cnt", cnt1, 1);
        chk("n1_done", done1, 1);
        chk("n1_pass", pass1, 1);

        run_b(1);
        run_b(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/misr_8_bist.md
Name: misr_8_bist

Overview:
- 8-bit multiple-input signature register (MISR) with a BIST sequencing FSM. It sits directly downstream of the 8-bit LFSR pattern generator.
- Compacts the circuit-under-test response driven by the LFSR patterns into an 8-bit signature over a fixed pattern count.
- Enables the upstream LFSR only while compacting.
- Compares the final signature against a golden value and reports pass/fail.

Parameters:
- WIDTH, 8, signature/data width; the block is verified at 8 only.
- POLY, 8'h1D, feedback taps (x^8+x^4+x^3+x^2+1), Galois form.
- SEED, 8'h00, signature value loaded on each start.
- NUM_PATTERNS, 255, number of compaction cycles per run; legal range 1..2^CNT_W.
- CNT_W, 8, pattern counter width.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- start  input  1  run request; sampled in IDLE or DONE.
- din  input  WIDTH  CUT response word, compacted every RUN cycle.
- golden  input  WIDTH  expected signature; sampled on the final compaction edge.
- lfsr_en  output  1  enable to upstream LFSR; high exactly in RUN.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- pass  output  1  registered compare result; valid while done=1.
- signature  output  WIDTH  current MISR contents.
- pattern_cnt  output  CNT_W  compaction cycles completed in current run.

Behaviour:
- Reset (async, RST=1): state=IDLE, signature=SEED, pattern_cnt=0, pass=0, done=0, busy=0, lfsr_en=0. Reset takes effect immediately at any point, including mid-RUN; any run in progress is abandoned and no partial result is reported.
- States: IDLE, RUN, DONE. State is fully registered; busy, done and lfsr_en decode from state only.
- IDLE:
  - start=1 at an edge -> signature<=SEED, pattern_cnt<=0, state<=RUN.
  - start=0 -> hold.
- RUN, each edge:
  - signature <= (signature<<1) ^ (signature[7] ? POLY : 0) ^ din.
  - pattern_cnt <= pattern_cnt+1.
  - start is ignored.
- Final compaction: the edge at which pattern_cnt==NUM_PATTERNS-1 performs the last compaction and sets state<=DONE, pattern_cnt<=NUM_PATTERNS (modulo 2^CNT_W), and pass<=(next signature==golden).
- Latency: start sampled at edge 0; compaction on edges 1..NUM_PATTERNS; done=1 is visible after edge NUM_PATTERNS. lfsr_en is high for exactly NUM_PATTERNS cycles.
- DONE:
  - Signature, pattern_cnt and pass are held.
  - start=1 -> restart exactly as from IDLE: reload SEED, clear pass and pattern_cnt, state<=RUN.
- NUM_PATTERNS=1: a single compaction, then DONE.
- NUM_PATTERNS=2^CNT_W: pattern_cnt reads 0 in DONE. The terminal compare uses pattern_cnt==NUM_PATTERNS-1, so it does not overflow.
- din and golden are don't-care outside RUN. X on din outside RUN must not affect any state.

Test Plan:
- Single-bit, LSB: SEED=0, NUM_PATTERNS=3, din=01,00,00 -> signature 01,02,04; done=1 after edge 3; golden=04 gives pass=1, golden=05 gives pass=0.
- Feedback path: NUM_PATTERNS=3, din=80,00,00 -> signature 80,1D,3A; pass=1 with golden=3A.
- Handshake timing: start pulse at cycle 5 -> busy/lfsr_en high cycles 6..6+N-1; done rises the next cycle. A start pulse during RUN leaves pattern_cnt progression unchanged.
- Restart from DONE: after a run with signature 3A, assert start -> signature=00, pattern_cnt=0, pass=0, busy=1 after one edge; the second identical run reproduces 3A.
- Async reset mid-RUN: assert RST between edges at pattern_cnt=2 -> all outputs return to reset values immediately (no clock needed); after release the block stays in IDLE until start.
- All-zero din, SEED=0, NUM_PATTERNS=255 -> signature stays 00, pattern_cnt=255 in DONE, pass=1 with golden=00.
